// File: rtl/blinky_echo.sv
// Board bring-up top: LED blinker plus UART 8N1 byte echo (RXD -> TXD).
// Define BLINKY_RX_ACTIVITY_EN to invert the LED briefly on each good byte.
module blinky_echo #(
    parameter int CLK_HZ   = 12_000_000,
    parameter int BAUD     = 115_200,
    parameter int BLINK_HZ = 1
) (
    input  logic CLK,
    input  logic RST,
    output logic LED,
    input  logic RXD,
    output logic TXD
);

    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BW   = $clog2(HALF + 1);
    localparam int CW   = $clog2(CPB + 1);

    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] MID_LAST  = CW'(CPB / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [BW-1:0] blink_cnt;
    logic          blink;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == HALF_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // rxs_d lets IDLE react only to a falling edge, so a held break is ignored
    logic rx_meta, rxs, rxs_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    logic [1:0]    rx_st;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic          rx_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_st    <= S_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_st)
                S_IDLE: begin
                    if (rxs_d && !rxs) begin
                        rx_st  <= S_START;
                        rx_cnt <= '0;
                    end
                end
                S_START: begin
                    if (rx_cnt == MID_LAST) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        rx_st  <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxs, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7)
                            rx_st <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_valid <= rxs;
                        rx_st    <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    logic [1:0]    tx_st;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;
    logic          txd;
    logic [7:0]    hold;
    logic          hold_full;
    logic          tx_load;

    // Loading straight out of the stop bit keeps back-to-back echo drift-free
    assign tx_load = hold_full &&
                     (tx_st == S_IDLE ||
                      (tx_st == S_STOP && tx_cnt == BIT_LAST));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (rx_valid && (!hold_full || tx_load)) begin
            hold      <= rx_shift;
            hold_full <= 1'b1;
        end else if (tx_load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_st    <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else if (tx_load) begin
            tx_st    <= S_START;
            tx_cnt   <= '0;
            tx_shift <= hold;
            txd      <= 1'b0;
        end else begin
            case (tx_st)
                S_IDLE: txd <= 1'b1;
                S_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_st    <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        tx_idx <= tx_idx + 3'd1;
                        if (tx_idx == 3'd7) begin
                            txd   <= 1'b1;
                            tx_st <= S_STOP;
                        end else begin
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: begin
                    if (tx_cnt == BIT_LAST)
                        tx_st <= S_IDLE;
                    else
                        tx_cnt <= tx_cnt + CW'(1);
                end
            endcase
        end
    end

    assign TXD = txd;

`ifdef BLINKY_RX_ACTIVITY_EN
    localparam int ACT = (HALF / 4 < 1) ? 1 : HALF / 4;
    localparam int AW  = $clog2(ACT + 1);

    logic [AW-1:0] act;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            act <= '0;
        else if (rx_valid)
            act <= AW'(ACT);
        else if (act != '0)
            act <= act - AW'(1);
    end

    assign LED = (act != '0) ? ~blink : blink;
`else
    assign LED = blink;
`endif

endmodule

// File: tb/tb_blinky_echo.sv
// Directed bench for blinky_echo: 10 clk/bit UART, 50-cycle blink half period.
// Build with BLINKY_RX_ACTIVITY_EN to add the LED activity step.
module tb_blinky_echo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic led;
    logic txd;

    int compared   = 0;
    int mismatched = 0;

    blinky_echo #(
        .CLK_HZ  (1000),
        .BAUD    (100),
        .BLINK_HZ(10)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .LED(led),
        .RXD(rxd),
        .TXD(txd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (10) tick();
        end
    endtask

    task automatic check_tx(input string tag, input logic [7:0] b,
                            input int wait_exp);
        logic [9:0] f;
        int n;
        f = {1'b1, b, 1'b0};
        n = 0;
        while (txd !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, n, wait_exp);
        if (n < 400) begin
            for (int c = 0; c < 100; c++) begin
                chk($sformatf("%s_c%0d", tag, c), 32'(txd), 32'(f[c / 10]));
                tick();
            end
        end
    endtask

    task automatic watch_idle(input string tag, input int cycles);
        int lows;
        lows = 0;
        repeat (cycles) begin
            if (txd !== 1'b1)
                lows++;
            tick();
        end
        chk(tag, lows, 0);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        repeat (60) tick();
        chk("pre_reset_led", 32'(led), 1);

        #3 rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led), 0);
        chk("async_rst_txd", 32'(txd), 1);
        repeat (5) tick();
        rst = 1'b0;

        for (int k = 1; k <= 200; k++) begin
            tick();
            chk($sformatf("blink_led_k%0d", k), 32'(led), (k / 50) % 2);
            chk($sformatf("blink_txd_k%0d", k), 32'(txd), 1);
        end

        fork
            send_byte(8'hA5, 1'b1);
            check_tx("echo_a5", 8'hA5, 100);
        join
        repeat (20) tick();

        fork
            begin
                send_byte(8'h00, 1'b1);
                send_byte(8'hFF, 1'b1);
                send_byte(8'h55, 1'b1);
            end
            begin
                check_tx("b2b_00", 8'h00, 100);
                check_tx("b2b_ff", 8'hFF, 0);
                check_tx("b2b_55", 8'h55, 0);
            end
        join
        repeat (20) tick();

        rxd = 1'b0;
        repeat (3) tick();
        rxd = 1'b1;
        watch_idle("glitch_idle", 150);

        fork
            begin
                send_byte(8'h3C, 1'b0);
                rxd = 1'b1;
                repeat (20) tick();
            end
            watch_idle("framing_idle", 130);
        join

        fork
            send_byte(8'h81, 1'b1);
            check_tx("echo_81", 8'h81, 100);
        join
        repeat (20) tick();

`ifdef BLINKY_RX_ACTIVITY_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fork
            send_byte(8'h11, 1'b1);
            for (int j = 1; j <= 130; j++) begin
                tick();
                chk($sformatf("act_led_j%0d", j), 32'(led),
                    32'(((j / 50) % 2) ^ ((j >= 99 && j <= 110) ? 1 : 0)));
            end
        join
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
